// File: rtl/sram_dump_reader_if.sv
// Dump-reader bus bundle: start command, SRAM read port and the word stream.
// The master modport is the reader itself; slave is the SRAM/consumer side.
interface sram_dump_reader_if #(
   parameter int unsigned word_size = 16,
   parameter int unsigned addr_size = 8
);
   logic                 start;
   logic [addr_size-1:0] start_addr;
   logic [addr_size-1:0] end_addr;
   logic                 mem_rd;
   logic [addr_size-1:0] mem_addr;
   logic [word_size-1:0] mem_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [word_size-1:0] out_data;
   logic [addr_size-1:0] out_addr;
   logic                 busy;
   logic                 done;

   modport master (
      input  start, start_addr, end_addr, mem_data, out_ready,
      output mem_rd, mem_addr, out_valid, out_data, out_addr, busy, done
   );

   modport slave (
      output start, start_addr, end_addr, mem_data, out_ready,
      input  mem_rd, mem_addr, out_valid, out_data, out_addr, busy, done
   );
endinterface

// File: rtl/sram_dump_reader.sv
// Walks an inclusive SRAM address range (wrapping) after a start pulse and
// streams each word with its address over valid/ready; done pulses at the end.
module sram_dump_reader #(
   parameter int unsigned word_size = 16,
   parameter int unsigned addr_size = 8
) (
   input  logic                clk,
   input  logic                rst,
   sram_dump_reader_if.master  bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_FIN
   } state_t;

   state_t               state_q, state_d;
   logic [addr_size-1:0] cur_q, cur_d;
   logic [addr_size-1:0] last_q, last_d;
   logic                 mem_rd_q, mem_rd_d;
   logic [addr_size-1:0] mem_addr_q, mem_addr_d;
   logic                 out_valid_q, out_valid_d;
   logic [word_size-1:0] out_data_q, out_data_d;
   logic [addr_size-1:0] out_addr_q, out_addr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [addr_size-1:0] cur_inc_c;

   assign cur_inc_c = cur_q + addr_size'(1);

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      mem_rd_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cur_d      = bus.start_addr;
               last_d     = bus.end_addr;
               busy_d     = 1'b1;
               mem_rd_d   = 1'b1;
               mem_addr_d = bus.start_addr;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            out_data_d  = bus.mem_data;
            out_addr_d  = cur_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (cur_q == last_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end else begin
                  cur_d      = cur_inc_c;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = cur_inc_c;
                  state_d    = S_REQ;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         last_q      <= '0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         mem_rd_q    <= mem_rd_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_sram_dump_reader.sv
// Bench for sram_dump_reader: synchronous SRAM model, negedge stream monitor,
// directed scenarios plus randomized ranges/backpressure against a range model.
module tb_sram_dump_reader;
   localparam int unsigned WS = 16;
   localparam int unsigned AS = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_dump_reader_if #(.word_size(WS), .addr_size(AS)) bus ();
   sram_dump_reader #(.word_size(WS), .addr_size(AS)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {logic [7:0] a; logic [15:0] d;} beat_t;

   // SRAM: data appears the cycle after the read strobe
   logic [15:0] mem [256];
   logic [15:0] mem_data_r;
   always @(posedge clk) if (bus.mem_rd === 1'b1) mem_data_r <= mem[bus.mem_addr];
   assign bus.mem_data = mem_data_r;

   beat_t got_q[$];
   beat_t exp_q[$];
   int n_cmp = 0, n_err = 0;
   int cyc = 0, hs_cyc, done_cyc, done_cnt, rd_cnt, rd_b2b, unstable;
   bit prev_stall, prev_rd, ready_rand;
   logic [15:0] prev_d;
   logic [7:0]  prev_a;

   // Monitor samples mid-cycle, so each entry is the value seen across one rising edge
   always @(negedge clk) begin
      cyc++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         got_q.push_back('{a: bus.out_addr, d: bus.out_data});
         hs_cyc = cyc;
      end
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.mem_rd === 1'b1) rd_cnt++;
      if (bus.mem_rd === 1'b1 && prev_rd) rd_b2b++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_d || bus.out_addr !== prev_a))
         unstable++;
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      prev_rd    = (bus.mem_rd === 1'b1);
      prev_d     = bus.out_data;
      prev_a     = bus.out_addr;
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (ready_rand) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Reference: every address from sa up to ea inclusive, modulo 256
   function automatic void build_exp(input logic [7:0] sa, input logic [7:0] ea);
      int n;
      exp_q.delete();
      n = int'(8'(ea - sa)) + 1;
      for (int i = 0; i < n; i++) exp_q.push_back('{a: 8'(sa + i), d: mem[8'(sa + i)]});
   endfunction

   task automatic clr_mon();
      got_q.delete();
      done_cnt = 0; rd_cnt = 0; rd_b2b = 0; unstable = 0;
      hs_cyc = 0; done_cyc = 0; prev_stall = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Returns just after the edge that accepts start
   task automatic drive_start(input logic [7:0] sa, input logic [7:0] ea);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.start_addr = sa; bus.end_addr = ea;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      n_cmp++; if (bus.mem_rd !== 1'b0)     begin n_err++; $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
      n_cmp++; if (bus.mem_addr !== 8'h00)  begin n_err++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
      n_cmp++; if (bus.out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 16'h0)  begin n_err++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
      n_cmp++; if (bus.out_addr !== 8'h00)  begin n_err++; $display("FAIL rst_out_addr: got %h want 00", bus.out_addr); end
      n_cmp++; if (bus.busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0)       begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_program();
      bit ok;
      mem[0] = 16'h2000; mem[1] = 16'h05B2; mem[2] = 16'h8000; mem[3] = 16'hD000; mem[4] = 16'h7000;
      build_exp(8'd0, 8'd4);
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd0, 8'd4);
      @(negedge clk);
      n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'd0 || bus.busy !== 1'b1)
         begin n_err++; $display("FAIL prog_req: got rd=%b addr=%h busy=%b want 1/00/1", bus.mem_rd, bus.mem_addr, bus.busy); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.mem_rd !== 1'b0)
         begin n_err++; $display("FAIL prog_wait: got valid=%b rd=%b want 0/0", bus.out_valid, bus.mem_rd); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h2000 || bus.out_addr !== 8'd0)
         begin n_err++; $display("FAIL prog_first: got valid=%b %h@%h want 1 2000@00", bus.out_valid, bus.out_data, bus.out_addr); end
      wait_done(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL prog_timeout: got no done want done"); end
      tick(4);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL prog_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL prog_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL prog_done_cnt: got %0d want 1", done_cnt); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL prog_busy_end: got %b want 0", bus.busy); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int rd0, t;
      build_exp(8'd0, 8'd4);
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd0, 8'd4);
      t = 0;
      while (got_q.size() < 1 && t < 20) begin tick(1); t++; end
      bus.out_ready = 1'b0;
      t = 0;
      while (bus.out_valid !== 1'b1 && t < 20) begin tick(1); t++; end
      rd0 = rd_cnt;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h05B2 || bus.out_addr !== 8'd1)
            begin n_err++; $display("FAIL bp_hold%0d: got v=%b %h@%h want 1 05B2@01", k, bus.out_valid, bus.out_data, bus.out_addr); end
         tick(1);
      end
      n_cmp++; if (rd_cnt != rd0) begin n_err++; $display("FAIL bp_extra_rd: got %0d reads want %0d", rd_cnt, rd0); end
      bus.out_ready = 1'b1;
      wait_done(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: got no done want done"); end
      tick(2);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (rd_cnt != 5 || unstable != 0)
         begin n_err++; $display("FAIL bp_rd_stable: got rd=%0d unstable=%0d want 5/0", rd_cnt, unstable); end
   endtask

   task automatic test_wrap();
      bit ok;
      mem[254] = 16'hAAAA; mem[255] = 16'hBBBB; mem[0] = 16'h2000;
      build_exp(8'd254, 8'd0);
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd254, 8'd0);
      wait_done(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got no done want done"); end
      tick(2);
      n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", got_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_single();
      mem[3] = 16'hD000;
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd3, 8'd3);
      tick(3);
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0)
         begin n_err++; $display("FAIL single_fin: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
      bus.start = 1'b1; bus.start_addr = 8'd10; bus.end_addr = 8'd10;
      tick(1);
      bus.start = 1'b0;
      tick(6);
      n_cmp++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== '{a: 8'd3, d: 16'hD000}))
         begin n_err++; $display("FAIL single_word: got %0d words first %h want 1 word 03/D000", got_q.size(), got_q.size() ? got_q[0] : '0); end
      n_cmp++; if (done_cyc - hs_cyc != 1) begin n_err++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - hs_cyc); end
      n_cmp++; if (rd_cnt != 1 || bus.busy !== 1'b0)
         begin n_err++; $display("FAIL single_fin_start: got rd=%0d busy=%b want 1/0", rd_cnt, bus.busy); end
   endtask

   task automatic test_start_busy();
      bit ok;
      int t;
      build_exp(8'd0, 8'd4);
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd0, 8'd4);
      t = 0;
      while (got_q.size() < 2 && t < 30) begin tick(1); t++; end
      bus.start = 1'b1; bus.start_addr = 8'd0; bus.end_addr = 8'd1;
      tick(3);
      bus.start = 1'b0;
      wait_done(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL busy_timeout: got no done want done"); end
      tick(8);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL busy_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL busy_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t;
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd0, 8'd4);
      t = 0;
      while (got_q.size() < 2 && t < 30) begin tick(1); t++; end
      bus.out_ready = 1'b0;
      t = 0;
      while (bus.out_valid !== 1'b1 && t < 20) begin tick(1); t++; end
      n_cmp++; if (bus.out_addr !== 8'd2) begin n_err++; $display("FAIL rmid_at_word2: got %h want 02", bus.out_addr); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_cmp++; if ({bus.mem_rd, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_addr, bus.busy, bus.done} !== '0)
         begin n_err++; $display("FAIL rmid_clear: got rd=%b ma=%h v=%b d=%h a=%h busy=%b done=%b want all 0",
               bus.mem_rd, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_addr, bus.busy, bus.done); end
      tick(8);
      n_cmp++; if (done_cnt != 0 || bus.busy !== 1'b0)
         begin n_err++; $display("FAIL rmid_no_done: got done_cnt=%0d busy=%b want 0/0", done_cnt, bus.busy); end
      build_exp(8'd0, 8'd4);
      clr_mon(); bus.out_ready = 1'b1;
      drive_start(8'd0, 8'd4);
      wait_done(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_timeout: got no done want done"); end
      tick(2);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [7:0] sa, ea;
      for (int it = 0; it < 7; it++) begin
         foreach (mem[j]) mem[j] = 16'($urandom);
         sa = 8'($urandom);
         ea = 8'(sa + $urandom_range(0, 24));
         if (it == 6) begin sa = 8'd0; ea = 8'd255; end
         build_exp(sa, ea);
         clr_mon(); ready_rand = 1'b1;
         drive_start(sa, ea);
         wait_done(12 * exp_q.size() + 60, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd%0d_timeout: got no done want done", it); end
         tick(2);
         n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
         foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
         end
         n_cmp++; if (done_cnt != 1 || rd_cnt != exp_q.size() || rd_b2b != 0 || unstable != 0)
            begin n_err++; $display("FAIL rnd%0d_proto: got done=%0d rd=%0d b2b=%0d unstable=%0d want 1/%0d/0/0",
                  it, done_cnt, rd_cnt, rd_b2b, unstable, exp_q.size()); end
         ready_rand = 1'b0;
         tick(2);
      end
   endtask

   initial begin
      rst = 1'b1;
      ready_rand = 1'b0;
      bus.start = 1'b0; bus.start_addr = '0; bus.end_addr = '0; bus.out_ready = 1'b0;
      foreach (mem[j]) mem[j] = 16'($urandom);
      clr_mon();
      test_reset();
      test_program();
      test_backpressure();
      test_wrap();
      test_single();
      test_start_busy();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
